// File: rtl/edge_arb_pkg.sv
// Shared types and default parameters for the edge event arbiter.
// The optional drop counter is enabled by defining EDGE_ARB_DROP_CNT_EN.
package edge_arb_pkg;

    localparam int NUM_IN_DEF = 2;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/edge_arb_rr_pick.sv
// Combinational round-robin picker: the first set bit of pending, searching
// upward from last_grant+1 and wrapping modulo NUM_IN.
module edge_arb_rr_pick
    import edge_arb_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] pending,
    input  logic [ID_W-1:0]   last_grant,
    output logic [ID_W-1:0]   pick,
    output logic              any
);

    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        any  = 1'b0;
        // k runs to NUM_IN so last_grant itself is considered last.
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(last_grant) + k) % NUM_IN;
            if (!any && pending[idx]) begin
                any  = 1'b1;
                pick = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector with one pending event per input, served round-robin
// over a valid/ready port. Define EDGE_ARB_DROP_CNT_EN to build the drop counter.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int ID_W   = $clog2(NUM_IN),
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] data_in,
    input  logic              enable,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    input  logic              evt_ready,
    output logic              evt_overrun,
    input  logic              ovr_clr,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Handshake: an event transfers on a clk edge where evt_valid & evt_ready;
    // once raised, evt_valid holds with evt_id stable until that transfer.

    arb_state_t        state, state_next;
    logic [NUM_IN-1:0] prev;
    logic [NUM_IN-1:0] pending;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] id_mask;
    logic [NUM_IN-1:0] grant_mask;
    logic [NUM_IN-1:0] drop;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   pick_idle, pick_next;
    logic              any_idle, any_next;
    logic              xfer;

    assign xfer = evt_valid & evt_ready;
    assign rise = data_in & ~prev & {NUM_IN{enable}};

    always_comb begin
        id_mask         = '0;
        id_mask[evt_id] = 1'b1;
    end

    assign grant_mask = xfer ? id_mask : '0;
    // A clear and a new edge on the same input is a fresh event, not a drop.
    assign drop       = rise & pending & ~grant_mask;

    edge_arb_rr_pick #(.NUM_IN(NUM_IN), .ID_W(ID_W)) u_pick_idle (
        .pending    (pending),
        .last_grant (last_grant),
        .pick       (pick_idle),
        .any        (any_idle)
    );

    edge_arb_rr_pick #(.NUM_IN(NUM_IN), .ID_W(ID_W)) u_pick_next (
        .pending    (pending & ~id_mask),
        .last_grant (evt_id),
        .pick       (pick_next),
        .any        (any_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev        <= '1;
            pending     <= '0;
            evt_overrun <= 1'b0;
        end else begin
            prev    <= data_in;
            pending <= (pending & ~grant_mask) | rise;
            if (|drop)
                evt_overrun <= 1'b1;
            else if (ovr_clr)
                evt_overrun <= 1'b0;
        end
    end

`ifdef EDGE_ARB_DROP_CNT_EN
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = ovr_clr ? '0 : drop_cnt;
        for (int i = 0; i < NUM_IN; i++) begin
            if (drop[i] && cnt_next != '1)
                cnt_next = cnt_next + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt <= '0;
        else
            drop_cnt <= cnt_next;
    end
`else
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_idle) state_next = OFFER;
            OFFER:   if (xfer && !any_next) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        evt_valid = (state == OFFER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_id     <= '0;
            last_grant <= ID_W'(NUM_IN - 1);
        end else begin
            if (state == IDLE && any_idle)
                evt_id <= pick_idle;
            if (xfer) begin
                last_grant <= evt_id;
                if (any_next)
                    evt_id <= pick_next;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with a cycle-level reference model.
// Drop-count expectations follow EDGE_ARB_DROP_CNT_EN.
module tb_edge_event_arbiter;

    localparam int NUM_IN  = 2;
    localparam int ID_W    = 1;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EDGE_ARB_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_IN-1:0] data_in;
    logic              enable;
    logic              evt_valid;
    logic [ID_W-1:0]   evt_id;
    logic              evt_ready;
    logic              evt_overrun;
    logic              ovr_clr;
    logic [CNT_W-1:0]  drop_cnt;

    int vectors = 0;
    int errors  = 0;

    edge_event_arbiter #(.NUM_IN(NUM_IN), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .enable      (enable),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ready   (evt_ready),
        .evt_overrun (evt_overrun),
        .ovr_clr     (ovr_clr),
        .drop_cnt    (drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // reference model
    bit              m_live = 1'b0;
    bit [NUM_IN-1:0] m_prev, m_pend;
    bit              m_valid, m_ovr;
    int              m_id, m_last, m_cnt;

    function automatic int rr_next(input bit [NUM_IN-1:0] p, input int from);
        for (int k = 1; k <= NUM_IN; k++)
            if (p[(from + k) % NUM_IN]) return (from + k) % NUM_IN;
        return -1;
    endfunction

    always @(posedge clk) begin
        bit              xfer, rs, clr;
        bit [NUM_IN-1:0] new_pend, rest;
        int              ndrop, base, nxt;
        if (rst) begin
            m_prev  = '1;
            m_pend  = '0;
            m_valid = 1'b0;
            m_id    = 0;
            m_last  = NUM_IN - 1;
            m_ovr   = 1'b0;
            m_cnt   = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            xfer     = m_valid && evt_ready;
            ndrop    = 0;
            new_pend = m_pend;
            for (int i = 0; i < NUM_IN; i++) begin
                rs  = data_in[i] && !m_prev[i] && enable;
                clr = xfer && (m_id == i);
                if (clr) new_pend[i] = 1'b0;
                if (rs) begin
                    if (m_pend[i] && !clr) ndrop++;
                    new_pend[i] = 1'b1;
                end
            end
            if (ndrop > 0) begin
                m_ovr = 1'b1;
                base  = ovr_clr ? 0 : m_cnt;
                m_cnt = (base + ndrop > CNT_MAX) ? CNT_MAX : base + ndrop;
            end else if (ovr_clr) begin
                m_ovr = 1'b0;
                m_cnt = 0;
            end
            if (!m_valid) begin
                nxt = rr_next(m_pend, m_last);
                if (nxt >= 0) begin
                    m_valid = 1'b1;
                    m_id    = nxt;
                end
            end else if (xfer) begin
                m_last     = m_id;
                rest       = m_pend;
                rest[m_id] = 1'b0;
                nxt        = rr_next(rest, m_id);
                if (nxt >= 0) m_id = nxt;
                else          m_valid = 1'b0;
            end
            m_pend = new_pend;
            m_prev = data_in;
        end
    end

    // scoreboard compare
    always @(negedge clk) begin
        if (m_live) begin
            check("valid", int'(evt_valid), int'(m_valid));
            if (m_valid) check("id", int'(evt_id), m_id);
            check("overrun", int'(evt_overrun), int'(m_ovr));
            check("drop_cnt", int'(drop_cnt), DROP_EN ? m_cnt : 0);
        end
    end

    // driver / directed sequence
    initial begin
        rst = 1'b1; data_in = 2'b11; enable = 1'b1; evt_ready = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_id", int'(evt_id), 0);
        check("rst_overrun", int'(evt_overrun), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);

        // line held high through reset release
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_high_no_evt", int'(evt_valid), 0);
        end

        // simultaneous rise, default last_grant: 0 then 1
        evt_ready = 1'b1; data_in = 2'b00; tick();
        data_in = 2'b11; tick();
        check("tie_wait", int'(evt_valid), 0);
        tick();
        check("tie_a_valid", int'(evt_valid), 1);
        check("tie_a_id", int'(evt_id), 0);
        tick();
        check("tie_b_valid", int'(evt_valid), 1);
        check("tie_b_id", int'(evt_id), 1);
        tick();
        check("tie_done", int'(evt_valid), 0);

        // single rise on input 0: latency and single-cycle offer
        data_in = 2'b00; tick();
        data_in = 2'b01; tick();
        check("lat_k", int'(evt_valid), 0);
        tick();
        check("lat_k1_valid", int'(evt_valid), 1);
        check("lat_k1_id", int'(evt_id), 0);
        tick();
        check("lat_k2_valid", int'(evt_valid), 0);

        // simultaneous rise with last_grant=0: 1 then 0
        data_in = 2'b00; tick();
        data_in = 2'b11; tick(); tick();
        check("rr_a_id", int'(evt_id), 1);
        tick();
        check("rr_b_valid", int'(evt_valid), 1);
        check("rr_b_id", int'(evt_id), 0);
        tick();
        check("rr_done", int'(evt_valid), 0);

        // overrun on input 1 while stalled, then ovr_clr
        evt_ready = 1'b0; data_in = 2'b00; tick();
        data_in = 2'b10; tick();
        data_in = 2'b00; tick();
        data_in = 2'b10; tick();
        check("ovr_flag", int'(evt_overrun), 1);
        check("ovr_drop_cnt", int'(drop_cnt), DROP_EN ? 1 : 0);
        check("ovr_id_held", int'(evt_id), 1);
        ovr_clr = 1'b1; tick();
        ovr_clr = 1'b0;
        check("clr_flag", int'(evt_overrun), 0);
        check("clr_drop_cnt", int'(drop_cnt), 0);
        check("clr_still_valid", int'(evt_valid), 1);
        evt_ready = 1'b1; tick();
        check("ovr_drain", int'(evt_valid), 0);
        data_in = 2'b00; tick();

        // enable low during rise, line stays high after enable returns
        enable = 1'b0; data_in = 2'b01; tick(); tick();
        check("disabled_rise", int'(evt_valid), 0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("enable_late", int'(evt_valid), 0);
        end
        data_in = 2'b00; tick();

        // reset mid-offer with both pending
        evt_ready = 1'b0; data_in = 2'b11; tick(); tick();
        check("pre_rst_valid", int'(evt_valid), 1);
        rst = 1'b1; tick();
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_id", int'(evt_id), 0);
        check("mid_rst_overrun", int'(evt_overrun), 0);
        rst = 1'b0; tick(); tick();
        check("post_rst_quiet", int'(evt_valid), 0);
        data_in = 2'b00; tick();

        // drop counter saturation while stalled
        for (int i = 0; i < 140; i++) begin
            data_in = 2'b11; tick();
            data_in = 2'b00; tick();
        end
        check("sat_drop_cnt", int'(drop_cnt), DROP_EN ? CNT_MAX : 0);
        check("sat_overrun", int'(evt_overrun), 1);
        // clear and two drops in the same cycle: drops win
        ovr_clr = 1'b1; data_in = 2'b11; tick();
        ovr_clr = 1'b0;
        check("clr_vs_drop_cnt", int'(drop_cnt), DROP_EN ? 2 : 0);
        check("clr_vs_drop_flag", int'(evt_overrun), 1);
        data_in = 2'b00; evt_ready = 1'b1; tick(); tick(); tick();
        check("sat_drained", int'(evt_valid), 0);

        // mixed traffic, checked by the model
        for (int i = 0; i < 80; i++) begin
            data_in   = NUM_IN'($urandom_range(0, 3));
            evt_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            ovr_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        ovr_clr = 1'b0; evt_ready = 1'b1; data_in = 2'b00; enable = 1'b1;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Detects rising edges on NUM_IN synchronous inputs and records one pending event per input. Pending events are presented one at a time to a single shared downstream consumer over a valid/ready handshake. Input selection is round-robin, so simultaneous edges on different inputs are all delivered without starvation. The block sits between the posedge_detector-style input lines and the event consumer, and sequences that shared consumer among the inputs.

## Interface
- NUM_IN, 2: number of monitored inputs (≥2).
- ID_W, $clog2(NUM_IN): width of the event id.
- CNT_W, 8: width of the drop counter.

- clk  in  1: single clock, rising-edge active.
- rst  in  1: synchronous, active-high reset.
- data_in  in  NUM_IN: monitored lines, synchronous to clk.
- enable  in  1: when 0, new edges are ignored; pending events are still delivered.
- evt_valid  out  1: an event is offered.
- evt_id  out  ID_W: index of the input whose edge is offered.
- evt_ready  in  1: consumer accepts; a transfer occurs on a clk edge where evt_valid & evt_ready.
- evt_overrun  out  1: sticky; an edge arrived on an input whose event was still pending.
- ovr_clr  in  1: clears evt_overrun and drop_cnt.
- drop_cnt  out  CNT_W: count of dropped edges (see Configuration).

## Operation
- prev register holds data_in from the previous cycle.
- edge[i] = data_in[i] & ~prev[i] & enable.
- pending[i] is set when edge[i] is 1.
- pending[i] is cleared when input i transfers.
- Clear and new edge on the same input in the same cycle: pending[i] stays 1. This counts as a new event, not a drop.
- Edge while pending[i]=1 and not being cleared: the edge is dropped, evt_overrun is set to 1, and drop_cnt is incremented.
- Drops on several inputs in the same cycle increment drop_cnt by the number of dropped edges, saturating at 2^CNT_W−1.
- ovr_clr and a drop in the same cycle: the drop wins. Result is evt_overrun=1 and drop_cnt=number of drops that cycle.
- FSM states: IDLE and OFFER.
  - IDLE → OFFER when any pending bit is 1. The round-robin pick is loaded into evt_id.
  - OFFER, valid & !ready: stay in OFFER. evt_id is held stable.
  - OFFER, transfer, and another pending input exists (excluding the one cleared): stay in OFFER and load the next pick.
  - OFFER, transfer, and no other pending input: go to IDLE.
- Round-robin pick: the first pending index searching upward from last_grant+1, modulo NUM_IN. last_grant is updated on each transfer.
- Once evt_valid is asserted it is never withdrawn without a transfer, except on rst.

## Timing
- Values after rst:
  - pending=0, state=IDLE, evt_valid=0, evt_id=0.
  - evt_overrun=0, drop_cnt=0.
  - last_grant=NUM_IN−1, so input 0 wins the first tie.
  - prev=all ones, so a line held high through reset produces no event.
- Latency: data_in[i] rises and is sampled at clk edge k → pending[i]=1 after edge k → evt_valid=1 with evt_id=i after edge k+1.
- Throughput: one event per cycle while evt_ready is held high and events are pending.
- rst asserted mid-offer: evt_valid drops after that clk edge and all pending events are discarded.
- A pulse on data_in must be high at one clk edge to be seen. A line held high produces a single event.

## Configuration
- EDGE_ARB_DROP_CNT_EN defined: drop_cnt counts and saturates as described above.
- EDGE_ARB_DROP_CNT_EN undefined: the counter logic is removed and drop_cnt is tied to 0. evt_overrun is unaffected.

## Structure
- Package edge_arb_pkg holds:
  - the FSM state enum {IDLE, OFFER};
  - the default parameter constants.
- Sub-module edge_arb_rr_pick is purely combinational. It takes pending and last_grant and returns the pick index plus an any-pending flag. The top level instantiates it twice:
  - once on pending, for the IDLE pick;
  - once on pending with the granted bit masked out, for the back-to-back pick.

## Test plan
- Reset release with data_in=2'b11 held: no evt_valid for 10 cycles.
- data_in[0] rises at edge k, evt_ready=1: evt_valid=1 and evt_id=0 after edge k+1, then evt_valid=0 the following cycle.
- Both inputs rise at the same edge, evt_ready=1: evt_id=0 then evt_id=1 on consecutive cycles. Repeat with last_grant=0: the order is 1 then 0.
- evt_ready=0 while data_in[1] pulses twice (0→1→0→1): evt_overrun=1 and drop_cnt=1. evt_id stays 1. Pulse ovr_clr: both clear.
- enable=0 during a rise on data_in[0]: no event. Set enable=1 while the line stays high: still no event.
- rst asserted while evt_valid=1 and pending=2'b11: all outputs return to their reset values the next cycle. With EDGE_ARB_DROP_CNT_EN undefined, drop_cnt stays 0 throughout the overrun scenario.
